adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares the core's single 32-bit `Adder` datapath between up to four requesters, such as ALU add/sub, branch-target and PC-increment logic. Each cycle it grants at most one requester and drives that requester's operands and carry-in into the adder. It captures the sum, carry and signed overflow in a one-deep result register. The result is returned to the requester identified by an ID tag, under a valid/ready handshake.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal values 2..4.
- `i_clk_1`  input  1: clock; all state updates on the rising edge.
- `i_rstN_1`  input  1: asynchronous, active-low reset.
- `i_reqValid_N`  input  NUM_REQ: per-requester request valid.
- `o_reqReady_N`  output  NUM_REQ: per-requester grant, one-hot or zero, combinational.
- `i_reqOperand1_N`  input  NUM_REQ*32: operand A. Requester k occupies bits [32k+31:32k].
- `i_reqOperand2_N`  input  NUM_REQ*32: operand B, same packing as operand A.
- `i_reqSub_N`  input  NUM_REQ: 1 selects A−B, 0 selects A+B.
- `o_adderOperand1_32`  output  32: to adder operand 1.
- `o_adderOperand2_32`  output  32: to adder operand 2.
- `o_cIn_1`  output  1: to adder carry-in.
- `i_adderSum_32`  input  32: from adder sum.
- `i_cOut_1`  input  1: from adder carry-out.
- `o_rspValid_1`  output  1: result register holds a result.
- `i_rspReady_1`  input  1: consumer accepts the result.
- `o_rspId_2`  output  2: index of the requester that owns the result.
- `o_rspSum_32`  output  32: registered sum.
- `o_rspCarry_1`  output  1: registered carry-out. For subtraction, 1 means no borrow.
- `o_rspOvf_1`  output  1: registered signed overflow.

## Operation
- **Slot free condition:** `slotFree = !o_rspValid_1 || i_rspReady_1`. No grant is issued while `slotFree` is 0.
- **Arbitration:** among valid requesters, exactly one is granted when `slotFree` is 1. The policy is set in Configuration. A transfer occurs in a cycle where `o_reqReady_N[k]` and `i_reqValid_N[k]` are both high.
- **Adder drive with a grant:**
  - `o_adderOperand1_32` = A.
  - `o_adderOperand2_32` = B if `i_reqSub_N[k]`=0, else ~B.
  - `o_cIn_1` = `i_reqSub_N[k]`.
- **Adder drive without a grant:** all three adder outputs are driven to 0.
- **Overflow:** `ovf = (opA[31] == opB'[31]) && (sum[31] != opA[31])`, where opB' is the operand actually driven to the adder. Arithmetic is modulo 2^32.
- **Result register states:** two states, EMPTY (`o_rspValid_1`=0) and FULL (`o_rspValid_1`=1).
  - EMPTY, with grant → FULL; load sum, carry, ovf and id.
  - FULL, `i_rspReady_1`=1 and grant → stays FULL; reload in the same cycle (back-to-back).
  - FULL, `i_rspReady_1`=1 and no grant → EMPTY. Data outputs hold their last values.
  - FULL, `i_rspReady_1`=0 → hold all outputs; no grant.
- **Requester rule:** a requester must hold its valid and operands stable until granted. The arbiter may re-arbitrate each cycle, and a request from a losing requester is not lost.
- **Reset values:**
  - `o_rspValid_1`=0, `o_rspId_2`=0, `o_rspSum_32`=0, `o_rspCarry_1`=0, `o_rspOvf_1`=0.
  - Round-robin pointer = 0.
  - `o_reqReady_N`, adder operands and `o_cIn_1` evaluate to 0 while `i_rstN_1`=0.
- **Reset mid-operation:** a pending result is discarded without being delivered.

## Timing
- Grant, adder drive and `o_reqReady_N` are combinational from the request inputs, `i_rspReady_1` and state. There is no path from `i_adderSum_32` to `o_reqReady_N`.
- Latency: request accepted in cycle N → result appears with `o_rspValid_1`=1 in cycle N+1.
- Throughput: one operation per cycle while `i_rspReady_1` is held at 1.
- Stall: if `i_rspReady_1`=0 while FULL, all `o_reqReady_N` are 0 that cycle.
- `o_rspValid_1` and the data outputs change only on a clock edge or on reset.

## Configuration
- `ADDER_ARB_RR_EN` **defined:** round-robin arbitration.
  - The pointer advances to (granted index + 1) mod NUM_REQ on each transfer.
  - The search starts at the pointer.
  - The pointer holds when there is no transfer.
- `ADDER_ARB_RR_EN` **undefined:** fixed priority, with index 0 highest. There is no pointer register.

## Test plan
- **Single add:** after reset, req0 A=0x0000_0005, B=0x0000_0003, sub=0 → ready0=1 in cycle N. In N+1: rspValid=1, id=0, sum=0x0000_0008, carry=0, ovf=0.
- **Subtract and overflow:**
  - req1 0x0000_0003−0x0000_0005 → sum=0xFFFF_FFFE, carry=0, ovf=0.
  - req1 0x8000_0000−0x0000_0001 → sum=0x7FFF_FFFF, carry=1, ovf=1.
- **Add wrap:** 0xFFFF_FFFF+1 → sum=0, carry=1, ovf=0. 0x7FFF_FFFF+1 → sum=0x8000_0000, ovf=1.
- **Contention, all valid continuously, rspReady=1:**
  - With `ADDER_ARB_RR_EN`: grants 0,1,2,0,1,2.
  - Without it: grant 0 every cycle.
  - In both cases the ids appear one cycle later, one per cycle, with no gaps.
- **Backpressure:** FULL with rspReady=0 for 3 cycles → all ready=0, and sum/id held stable. With rspReady=1 and req2 valid in the same cycle → back-to-back reload, rspValid stays 1.
- **Reset mid-operation:** assert `i_rstN_1` low while FULL and between clock edges → `o_rspValid_1`=0 immediately, outputs=0, and the pointer returns to 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one 32-bit adder among NUM_REQ requesters, one-deep result register
// Optional: define ADDER_ARB_RR_EN for round-robin arbitration (fixed priority, index 0 highest, otherwise).
module adder_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic                    i_clk_1,
   input  logic                    i_rstN_1,
   input  logic [NUM_REQ-1:0]      i_reqValid_N,
   output logic [NUM_REQ-1:0]      o_reqReady_N,
   input  logic [NUM_REQ*32-1:0]   i_reqOperand1_N,
   input  logic [NUM_REQ*32-1:0]   i_reqOperand2_N,
   input  logic [NUM_REQ-1:0]      i_reqSub_N,
   output logic [31:0]             o_adderOperand1_32,
   output logic [31:0]             o_adderOperand2_32,
   output logic                    o_cIn_1,
   input  logic [31:0]             i_adderSum_32,
   input  logic                    i_cOut_1,
   output logic                    o_rspValid_1,
   input  logic                    i_rspReady_1,
   output logic [1:0]              o_rspId_2,
   output logic [31:0]             o_rspSum_32,
   output logic                    o_rspCarry_1,
   output logic                    o_rspOvf_1
);

   logic        slotFree;
   logic        gntAny;
   logic [1:0]  gntIdx;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        cIn;
   logic        ovfNext;

   assign slotFree = !o_rspValid_1 || i_rspReady_1;

`ifdef ADDER_ARB_RR_EN
   localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);
   logic [1:0] rrPtr;
   logic [2:0] candIdx;

   // Search starts at the pointer and wraps modulo NUM_REQ; first valid wins.
   always_comb begin
      gntAny  = 1'b0;
      gntIdx  = 2'd0;
      candIdx = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         candIdx = 3'(rrPtr) + 3'(i);
         if (candIdx >= 3'(NUM_REQ)) candIdx = candIdx - 3'(NUM_REQ);
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!gntAny && candIdx == 3'(k) && i_reqValid_N[k]) begin
               gntAny = 1'b1;
               gntIdx = 2'(k);
            end
         end
      end
      gntAny = gntAny && slotFree && i_rstN_1;
   end

   always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
      if (!i_rstN_1) begin
         rrPtr <= 2'd0;
      end else if (gntAny) begin
         rrPtr <= (gntIdx == LAST_IDX) ? 2'd0 : gntIdx + 2'd1;
      end
   end
`else
   always_comb begin
      gntAny = 1'b0;
      gntIdx = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_reqValid_N[k]) begin
            gntAny = 1'b1;
            gntIdx = 2'(k);
         end
      end
      gntAny = gntAny && slotFree && i_rstN_1;
   end
`endif

   // Operand mux; everything is zero when nobody holds the grant.
   always_comb begin
      opA          = 32'd0;
      opB          = 32'd0;
      cIn          = 1'b0;
      o_reqReady_N = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gntAny && gntIdx == 2'(k)) begin
            o_reqReady_N[k] = 1'b1;
            opA = i_reqOperand1_N[32*k +: 32];
            opB = i_reqSub_N[k] ? ~i_reqOperand2_N[32*k +: 32] : i_reqOperand2_N[32*k +: 32];
            cIn = i_reqSub_N[k];
         end
      end
   end

   assign o_adderOperand1_32 = opA;
   assign o_adderOperand2_32 = opB;
   assign o_cIn_1            = cIn;
   assign ovfNext = (opA[31] == opB[31]) && (i_adderSum_32[31] != opA[31]);

   always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
      if (!i_rstN_1) begin
         o_rspValid_1 <= 1'b0;
         o_rspId_2    <= 2'd0;
         o_rspSum_32  <= 32'd0;
         o_rspCarry_1 <= 1'b0;
         o_rspOvf_1   <= 1'b0;
      end else if (gntAny) begin
         o_rspValid_1 <= 1'b1;
         o_rspId_2    <= gntIdx;
         o_rspSum_32  <= i_adderSum_32;
         o_rspCarry_1 <= i_cOut_1;
         o_rspOvf_1   <= ovfNext;
      end else if (i_rspReady_1) begin
         o_rspValid_1 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter (NUM_REQ=3)
module tb_adder_arbiter;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rstN;
   logic [N-1:0]  reqValid;
   logic [N-1:0]  reqReady;
   logic [N*32-1:0] reqOp1;
   logic [N*32-1:0] reqOp2;
   logic [N-1:0]  reqSub;
   logic [31:0]   adderOp1;
   logic [31:0]   adderOp2;
   logic          cIn;
   logic [31:0]   adderSum;
   logic          cOut;
   logic          rspValid;
   logic          rspReady;
   logic [1:0]    rspId;
   logic [31:0]   rspSum;
   logic          rspCarry;
   logic          rspOvf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Behavioural 32-bit adder standing in for the shared datapath.
   assign {cOut, adderSum} = {1'b0, adderOp1} + {1'b0, adderOp2} + 33'(cIn);

   adder_arbiter #(.NUM_REQ(N)) dut (
      .i_clk_1(clk), .i_rstN_1(rstN),
      .i_reqValid_N(reqValid), .o_reqReady_N(reqReady),
      .i_reqOperand1_N(reqOp1), .i_reqOperand2_N(reqOp2), .i_reqSub_N(reqSub),
      .o_adderOperand1_32(adderOp1), .o_adderOperand2_32(adderOp2), .o_cIn_1(cIn),
      .i_adderSum_32(adderSum), .i_cOut_1(cOut),
      .o_rspValid_1(rspValid), .i_rspReady_1(rspReady), .o_rspId_2(rspId),
      .o_rspSum_32(rspSum), .o_rspCarry_1(rspCarry), .o_rspOvf_1(rspOvf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setReq(input int k, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
      reqValid[k]       = v;
      reqOp1[32*k +: 32] = a;
      reqOp2[32*k +: 32] = b;
      reqSub[k]         = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chkRsp(input string tag, input logic [1:0] id, input logic [31:0] sum,
                         input logic carry, input logic ovf);
      chk({tag, ".valid"}, 64'(rspValid), 64'd1);
      chk({tag, ".id"},    64'(rspId),    64'(id));
      chk({tag, ".sum"},   64'(rspSum),   64'(sum));
      chk({tag, ".carry"}, 64'(rspCarry), 64'(carry));
      chk({tag, ".ovf"},   64'(rspOvf),   64'(ovf));
   endtask

   logic [1:0] expGnt [6];

   initial begin
      rstN = 1'b0; rspReady = 1'b1;
      reqValid = '0; reqOp1 = '0; reqOp2 = '0; reqSub = '0;
      for (int k = 0; k < N; k++) setReq(k, 1'b1, 32'h11 * (k + 1), 32'h2, 1'b1);
      #2;
      chk("rst.ready", 64'(reqReady), 64'd0);
      chk("rst.op1",   64'(adderOp1), 64'd0);
      chk("rst.op2",   64'(adderOp2), 64'd0);
      chk("rst.cin",   64'(cIn),      64'd0);
      chk("rst.valid", 64'(rspValid), 64'd0);
      chk("rst.sum",   64'(rspSum),   64'd0);
      chk("rst.id",    64'(rspId),    64'd0);
      reqValid = '0;
      tick();
      rstN = 1'b1;
      tick();

      // Single add
      setReq(0, 1'b1, 32'h5, 32'h3, 1'b0);
      #1;
      chk("add.ready", 64'(reqReady), 64'b001);
      chk("add.op2",   64'(adderOp2), 64'h3);
      chk("add.cin",   64'(cIn),      64'd0);
      tick();
      reqValid = '0;
      chkRsp("add", 2'd0, 32'h8, 1'b0, 1'b0);
      tick();
      chk("drain.valid", 64'(rspValid), 64'd0);
      chk("drain.hold",  64'(rspSum),   64'h8);

      // Subtract, then subtract with overflow back-to-back
      setReq(1, 1'b1, 32'h3, 32'h5, 1'b1);
      #1;
      chk("sub.ready", 64'(reqReady), 64'b010);
      chk("sub.op2",   64'(adderOp2), 64'hFFFF_FFFA);
      chk("sub.cin",   64'(cIn),      64'd1);
      tick();
      chkRsp("sub", 2'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      setReq(1, 1'b1, 32'h8000_0000, 32'h1, 1'b1);
      tick();
      chkRsp("subovf", 2'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Add wrap cases
      reqValid = '0;
      setReq(0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
      tick();
      chkRsp("wrap", 2'd0, 32'h0, 1'b1, 1'b0);
      setReq(0, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
      tick();
      chkRsp("addovf", 2'd0, 32'h8000_0000, 1'b0, 1'b1);

      // Backpressure: full with rspReady low for three cycles
      setReq(0, 1'b1, 32'd10, 32'd20, 1'b0);
      tick();
      chkRsp("bp.load", 2'd0, 32'd30, 1'b0, 1'b0);
      rspReady = 1'b0;
      setReq(0, 1'b1, 32'd7, 32'd7, 1'b0);
      setReq(2, 1'b1, 32'd100, 32'd1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp.ready", 64'(reqReady), 64'd0);
         chk("bp.sum",   64'(rspSum),   64'd30);
         chk("bp.id",    64'(rspId),    64'd0);
         chk("bp.valid", 64'(rspValid), 64'd1);
         tick();
      end
      rspReady = 1'b1;
      reqValid[0] = 1'b0;
      #1;
      chk("bp.release", 64'(reqReady), 64'b100);
      tick();
      chkRsp("bp.reload", 2'd2, 32'd101, 1'b0, 1'b0);
      reqValid = '0;
      setReq(1, 1'b1, 32'd40, 32'd2, 1'b0);
      tick();
      chkRsp("b2b", 2'd1, 32'd42, 1'b0, 1'b0);
      reqValid = '0;

      // Reset between edges while full
      #2;
      rstN = 1'b0;
      #1;
      chk("mrst.valid", 64'(rspValid), 64'd0);
      chk("mrst.sum",   64'(rspSum),   64'd0);
      chk("mrst.id",    64'(rspId),    64'd0);
      #1;
      rstN = 1'b1;
      tick();

      // Contention: every requester valid continuously
`ifdef ADDER_ARB_RR_EN
      expGnt = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
      expGnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      for (int k = 0; k < N; k++) setReq(k, 1'b1, 32'h100 * (k + 1), 32'(k), 1'b0);
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("cont.ready", 64'(reqReady), 64'(3'b001 << expGnt[c]));
         if (c > 0) begin
            chk("cont.valid", 64'(rspValid), 64'd1);
            chk("cont.id",    64'(rspId),    64'(expGnt[c-1]));
         end
         tick();
      end
      chk("cont.lastid",  64'(rspId),  64'(expGnt[5]));
      chk("cont.lastsum", 64'(rspSum), 64'(32'h100 * (expGnt[5] + 1) + expGnt[5]));
      reqValid = '0;
      tick();
      chk("end.valid", 64'(rspValid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
